slot_memory_responder: RTL and testbench

- Responder end of the slot memory bus.
- Mapper logic drives a combined request onto the bus: address, read/not-write, ram_cs and sram_cs.
- This block services that request. ram_cs goes to the SDRAM controller port (req/ack handshake); sram_cs goes to an on-chip battery-backed SRAM (BRAM, 1-cycle read latency).
- It holds the Z80 in WAIT until the result is ready, then returns read data to the slot data path.

---
 rtl/slot_memory_responder_pkg.sv | 20 ++
 rtl/mem_resp_timeout.sv | 39 +++
 rtl/slot_memory_responder.sv | 169 ++++++++++++++++
 tb/tb_slot_memory_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/slot_memory_responder_pkg.sv
// Shared types and constants for the slot memory responder.
//   mem_resp_state_t : responder FSM states
//   MEM_ADDR_W       : width of the mapper bus address
//   MEM_IDLE_ADDR    : address value the mapper drives when no access is in flight
//   DATA_IDLE        : open-bus value returned when there is no valid read
package slot_memory_responder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RAM_ACC,
        SRAM_ACC,
        SRAM_WAIT,
        DONE
    } mem_resp_state_t;

    localparam int unsigned           MEM_ADDR_W    = 27;
    localparam logic [MEM_ADDR_W-1:0] MEM_IDLE_ADDR = '1;
    localparam logic [7:0]            DATA_IDLE     = 8'hFF;

endpackage

// File: rtl/mem_resp_timeout.sv
// Saturating 8-bit cycle counter guarding the SDRAM handshake.
//   clk_sys / reset : system clock, asynchronous active-high reset
//   clr_i           : force the count to zero (has priority over en_i)
//   en_i            : count one cycle
//   hit_o           : the increment taken this cycle reaches LIMIT
// LIMIT is meaningful in the range 0..256; the count saturates at 255.
module mem_resp_timeout #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Compare the post-increment value so a LIMIT-cycle wait ends on the LIMIT-th cycle.
    assign hit_o = ({1'b0, cnt_q} + 9'd1) >= 9'(LIMIT);

endmodule

// File: rtl/slot_memory_responder.sv
// Responder end of the slot memory bus. Captures a mapper request on cpu_req, services it
// from SDRAM (req/ack handshake with timeout) or on-chip SRAM (1-cycle read latency), holds
// the CPU in WAIT meanwhile and returns read data to the slot data path.
//   clk_sys, reset                 : clock, asynchronous active-high reset
//   cpu_req, mem_addr, mem_rnw,
//   mem_ram_cs, mem_sram_cs, cpu_din : request from the mapper / CPU
//   sdram_req/we/addr/din, sdram_ack/dout : SDRAM controller port
//   sram_addr/we/din, sram_q       : SRAM port
//   cpu_wait                       : CPU wait request
//   data                           : read data to the slot mux (FF when no valid read)
//   timeout_err                    : sticky SDRAM timeout flag
module slot_memory_responder
    import slot_memory_responder_pkg::*;
#(
    parameter int unsigned RAM_AW  = 25,
    parameter int unsigned SRAM_AW = 18,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic                  mem_rnw,
    input  logic                  mem_ram_cs,
    input  logic                  mem_sram_cs,
    input  logic [7:0]            cpu_din,
    output logic                  sdram_req,
    output logic                  sdram_we,
    output logic [RAM_AW-1:0]     sdram_addr,
    output logic [7:0]            sdram_din,
    input  logic                  sdram_ack,
    input  logic [7:0]            sdram_dout,
    output logic [SRAM_AW-1:0]    sram_addr,
    output logic                  sram_we,
    output logic [7:0]            sram_din,
    input  logic [7:0]            sram_q,
    output logic                  cpu_wait,
    output logic [7:0]            data,
    output logic                  timeout_err
);

    mem_resp_state_t   state_q, state_d;
    logic [RAM_AW-1:0] addr_q, addr_d;
    logic              rnw_q, rnw_d;
    logic [7:0]        din_q, din_d;
    logic [7:0]        data_q, data_d;
    logic              sdram_req_q, sdram_req_d;
    logic              sdram_we_q, sdram_we_d;
    logic              sram_we_q, sram_we_d;
    logic              timeout_err_q, timeout_err_d;
    logic              to_hit;

    // Bits above the SDRAM window are dropped without a wrap check.
    if (RAM_AW < MEM_ADDR_W) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^mem_addr[MEM_ADDR_W-1:RAM_AW];
    end

    mem_resp_timeout #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk_sys (clk_sys),
        .reset   (reset),
        .clr_i   (state_q != RAM_ACC),
        .en_i    (state_q == RAM_ACC),
        .hit_o   (to_hit)
    );

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rnw_d         = rnw_q;
        din_d         = din_q;
        data_d        = data_q;
        sdram_req_d   = sdram_req_q;
        sdram_we_d    = sdram_we_q;
        sram_we_d     = 1'b0;
        timeout_err_d = timeout_err_q;

        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    addr_d = mem_addr[RAM_AW-1:0];
                    rnw_d  = mem_rnw;
                    din_d  = cpu_din;
                    if (mem_sram_cs) begin
                        // SRAM wins when both selects are set.
                        state_d   = SRAM_ACC;
                        sram_we_d = !mem_rnw;
                    end else if (mem_ram_cs) begin
                        state_d     = RAM_ACC;
                        sdram_req_d = 1'b1;
                        sdram_we_d  = !mem_rnw;
                    end else begin
                        data_d = DATA_IDLE;
                    end
                end
            end
            RAM_ACC: begin
                if (sdram_ack) begin
                    if (rnw_q) begin
                        data_d = sdram_dout;
                    end
                    sdram_req_d = 1'b0;
                    sdram_we_d  = 1'b0;
                    state_d     = DONE;
                end else if (to_hit) begin
                    sdram_req_d   = 1'b0;
                    sdram_we_d    = 1'b0;
                    data_d        = DATA_IDLE;
                    timeout_err_d = 1'b1;
                    state_d       = DONE;
                end
            end
            SRAM_ACC: begin
                state_d = rnw_q ? SRAM_WAIT : DONE;
            end
            SRAM_WAIT: begin
                data_d  = sram_q;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            rnw_q         <= 1'b0;
            din_q         <= 8'd0;
            data_q        <= DATA_IDLE;
            sdram_req_q   <= 1'b0;
            sdram_we_q    <= 1'b0;
            sram_we_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            rnw_q         <= rnw_d;
            din_q         <= din_d;
            data_q        <= data_d;
            sdram_req_q   <= sdram_req_d;
            sdram_we_q    <= sdram_we_d;
            sram_we_q     <= sram_we_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Wait must rise in the request cycle itself, before the FSM has left IDLE.
    assign cpu_wait = (state_q == RAM_ACC) || (state_q == SRAM_ACC) || (state_q == SRAM_WAIT) ||
                      ((state_q == IDLE) && cpu_req && (mem_ram_cs || mem_sram_cs));

    assign sdram_req   = sdram_req_q;
    assign sdram_we    = sdram_we_q;
    assign sdram_addr  = addr_q;
    assign sdram_din   = din_q;
    assign sram_addr   = addr_q[SRAM_AW-1:0];
    assign sram_we     = sram_we_q;
    assign sram_din    = din_q;
    assign data        = data_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_slot_memory_responder.sv
// Directed bench for slot_memory_responder: table of request vectors plus hand-written
// reset-mid-access sequence. Includes a behavioural 1-cycle-latency SRAM.
module tb_slot_memory_responder;
    import slot_memory_responder_pkg::*;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [26:0] mem_addr;
    logic        mem_rnw;
    logic        mem_ram_cs;
    logic        mem_sram_cs;
    logic [7:0]  cpu_din;
    logic        sdram_req;
    logic        sdram_we;
    logic [24:0] sdram_addr;
    logic [7:0]  sdram_din;
    logic        sdram_ack;
    logic [7:0]  sdram_dout;
    logic [17:0] sram_addr;
    logic        sram_we;
    logic [7:0]  sram_din;
    logic [7:0]  sram_q;
    logic        cpu_wait;
    logic [7:0]  data;
    logic        timeout_err;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk_sys = ~clk_sys;

    slot_memory_responder dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .mem_addr    (mem_addr),
        .mem_rnw     (mem_rnw),
        .mem_ram_cs  (mem_ram_cs),
        .mem_sram_cs (mem_sram_cs),
        .cpu_din     (cpu_din),
        .sdram_req   (sdram_req),
        .sdram_we    (sdram_we),
        .sdram_addr  (sdram_addr),
        .sdram_din   (sdram_din),
        .sdram_ack   (sdram_ack),
        .sdram_dout  (sdram_dout),
        .sram_addr   (sram_addr),
        .sram_we     (sram_we),
        .sram_din    (sram_din),
        .sram_q      (sram_q),
        .cpu_wait    (cpu_wait),
        .data        (data),
        .timeout_err (timeout_err)
    );

    logic [7:0] sram_mem [0:(1<<18)-1];

    always @(posedge clk_sys) begin
        if (sram_we) sram_mem[sram_addr] <= sram_din;
        sram_q <= sram_mem[sram_addr];
    end

    typedef struct {
        string       name;
        logic        rnw;
        logic        ram;
        logic        sram;
        logic [26:0] addr;
        logic [7:0]  din;
        int          ack_at;
        logic [7:0]  dout;
        int          exp_wait;
        int          exp_we;
        int          exp_req;
        logic [24:0] exp_req_addr;
        logic        exp_req_we;
        logic [7:0]  exp_req_din;
        logic [17:0] exp_we_addr;
        logic [7:0]  exp_we_din;
        logic [7:0]  exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one request in the current cycle and follow it until wait drops.
    // ack_at: cycle (1-based after cpu_req) on which to pulse sdram_ack, 0 = never.
    task automatic run_req(input logic rnw, input logic ram, input logic sram,
                           input logic [26:0] a, input logic [7:0] d,
                           input int ack_at, input logic [7:0] dout,
                           output int wait_cyc, output int we_cyc, output int req_cyc,
                           output logic [24:0] req_addr, output logic req_we,
                           output logic [7:0] req_din, output logic [17:0] we_addr,
                           output logic [7:0] we_din);
        int k;
        wait_cyc = 0; we_cyc = 0; req_cyc = 0;
        req_addr = '0; req_we = 1'b0; req_din = '0; we_addr = '0; we_din = '0;
        mem_addr = a; mem_rnw = rnw; cpu_din = d;
        mem_ram_cs = ram; mem_sram_cs = sram; cpu_req = 1'b1;
        #1;
        if (cpu_wait) wait_cyc++;
        @(posedge clk_sys); #1;
        cpu_req = 1'b0; mem_ram_cs = 1'b0; mem_sram_cs = 1'b0; mem_addr = MEM_IDLE_ADDR;
        k = 1;
        while (cpu_wait && k < 400) begin
            wait_cyc++;
            if (sram_we) begin
                we_cyc++; we_addr = sram_addr; we_din = sram_din;
            end
            if (sdram_req) begin
                req_cyc++; req_addr = sdram_addr; req_we = sdram_we; req_din = sdram_din;
            end
            sdram_ack  = (k == ack_at);
            sdram_dout = (k == ack_at) ? dout : 8'h00;
            @(posedge clk_sys); #1;
            k++;
        end
        sdram_ack = 1'b0;
        // The completion cycle must not strobe either memory.
        if (sram_we) we_cyc++;
        if (sdram_req) req_cyc++;
        @(posedge clk_sys); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          w, we, rq;
        logic [24:0] ra;
        logic        rwe;
        logic [7:0]  rd, wd;
        logic [17:0] wa;

        //            name        rnw   ram   sram  addr          din    ack dout   wait we req req_addr     rwe   rdin   we_addr     we_din data   err
        vecs[0] = '{"sram_rd",    1'b1, 1'b0, 1'b1, 27'h0000123, 8'h00, 0, 8'h00,  3,  0, 0,  25'h0,       1'b0, 8'h00, 18'h0,      8'h00, 8'h5A, 1'b0};
        vecs[1] = '{"sram_wr",    1'b0, 1'b0, 1'b1, 27'h003FFFF, 8'hC3, 0, 8'h00,  2,  1, 0,  25'h0,       1'b0, 8'h00, 18'h3FFFF,  8'hC3, 8'h5A, 1'b0};
        vecs[2] = '{"sram_rdbk",  1'b1, 1'b0, 1'b1, 27'h003FFFF, 8'h00, 0, 8'h00,  3,  0, 0,  25'h0,       1'b0, 8'h00, 18'h0,      8'h00, 8'hC3, 1'b0};
        vecs[3] = '{"sdram_rd",   1'b1, 1'b1, 1'b0, 27'h01ABCDE, 8'h00, 7, 8'h77,  8,  0, 7,  25'h1ABCDE,  1'b0, 8'h00, 18'h0,      8'h00, 8'h77, 1'b0};
        vecs[4] = '{"sdram_wr",   1'b0, 1'b1, 1'b0, 27'h6000010, 8'h5E, 1, 8'h11,  2,  0, 1,  25'h0000010, 1'b1, 8'h5E, 18'h0,      8'h00, 8'h77, 1'b0};
        vecs[5] = '{"both_cs",    1'b1, 1'b1, 1'b1, 27'h07C0456, 8'h00, 3, 8'h99,  3,  0, 0,  25'h0,       1'b0, 8'h00, 18'h0,      8'h00, 8'hA5, 1'b0};
        vecs[6] = '{"sdram_to",   1'b1, 1'b1, 1'b0, 27'h0000200, 8'h00, 0, 8'h00,  256, 0, 255, 25'h0000200, 1'b0, 8'h00, 18'h0,   8'h00, 8'hFF, 1'b1};
        vecs[7] = '{"no_cs",      1'b1, 1'b0, 1'b0, 27'h0000123, 8'h00, 0, 8'h00,  0,  0, 0,  25'h0,       1'b0, 8'h00, 18'h0,      8'h00, 8'hFF, 1'b1};
        vecs[8] = '{"sdram_after",1'b1, 1'b1, 1'b0, 27'h0000ABC, 8'h00, 3, 8'h3C,  4,  0, 3,  25'h0000ABC,  1'b0, 8'h00, 18'h0,      8'h00, 8'h3C, 1'b1};

        sram_mem[18'h00123] = 8'h5A;
        sram_mem[18'h00456] = 8'hA5;

        reset = 1'b1; cpu_req = 1'b0; mem_addr = MEM_IDLE_ADDR; mem_rnw = 1'b1;
        mem_ram_cs = 1'b0; mem_sram_cs = 1'b0; cpu_din = 8'h00;
        sdram_ack = 1'b0; sdram_dout = 8'h00;
        @(posedge clk_sys); @(posedge clk_sys); #1;
        chk("rst_data", data, 8'hFF);
        chk("rst_wait", cpu_wait, 1'b0);
        chk("rst_sdram_req", sdram_req, 1'b0);
        chk("rst_sdram_we", sdram_we, 1'b0);
        chk("rst_sram_we", sram_we, 1'b0);
        chk("rst_err", timeout_err, 1'b0);
        chk("rst_sdram_addr", sdram_addr, 25'h0);
        chk("rst_sram_addr", sram_addr, 18'h0);
        reset = 1'b0;
        @(posedge clk_sys); #1;

        for (int i = 0; i < 9; i++) begin
            run_req(vecs[i].rnw, vecs[i].ram, vecs[i].sram, vecs[i].addr, vecs[i].din,
                    vecs[i].ack_at, vecs[i].dout, w, we, rq, ra, rwe, rd, wa, wd);
            chk({vecs[i].name, "_wait"}, w, vecs[i].exp_wait);
            chk({vecs[i].name, "_sram_we"}, we, vecs[i].exp_we);
            chk({vecs[i].name, "_sdram_req"}, rq, vecs[i].exp_req);
            chk({vecs[i].name, "_data"}, data, vecs[i].exp_data);
            chk({vecs[i].name, "_err"}, timeout_err, vecs[i].exp_err);
            if (vecs[i].exp_req > 0) begin
                chk({vecs[i].name, "_req_addr"}, ra, vecs[i].exp_req_addr);
                chk({vecs[i].name, "_req_we"}, rwe, vecs[i].exp_req_we);
                if (vecs[i].exp_req_we) chk({vecs[i].name, "_req_din"}, rd, vecs[i].exp_req_din);
            end
            if (vecs[i].exp_we > 0) begin
                chk({vecs[i].name, "_we_addr"}, wa, vecs[i].exp_we_addr);
                chk({vecs[i].name, "_we_din"}, wd, vecs[i].exp_we_din);
            end
        end

        // Reset in the middle of an SDRAM access, then a stray late ack.
        mem_addr = 27'h0000055; mem_rnw = 1'b1; mem_ram_cs = 1'b1; cpu_req = 1'b1;
        @(posedge clk_sys); #1;
        cpu_req = 1'b0; mem_ram_cs = 1'b0; mem_addr = MEM_IDLE_ADDR;
        @(posedge clk_sys); #1;
        @(posedge clk_sys); #1;
        chk("mid_req_active", sdram_req, 1'b1);
        chk("mid_wait_active", cpu_wait, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_sdram_req", sdram_req, 1'b0);
        chk("mid_rst_wait", cpu_wait, 1'b0);
        chk("mid_rst_data", data, 8'hFF);
        chk("mid_rst_err", timeout_err, 1'b0);
        chk("mid_rst_addr", sdram_addr, 25'h0);
        @(posedge clk_sys); #1;
        reset = 1'b0;
        sdram_ack = 1'b1; sdram_dout = 8'h99;
        @(posedge clk_sys); #1;
        sdram_ack = 1'b0;
        @(posedge clk_sys); #1;
        chk("late_ack_data", data, 8'hFF);
        chk("late_ack_wait", cpu_wait, 1'b0);
        chk("late_ack_req", sdram_req, 1'b0);

        run_req(1'b1, 1'b0, 1'b1, 27'h0000123, 8'h00, 0, 8'h00, w, we, rq, ra, rwe, rd, wa, wd);
        chk("post_rst_wait", w, 3);
        chk("post_rst_data", data, 8'h5A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
